// File: rtl/cascade_tick_gen_pkg.sv
// ============================================================================
// cascade_tick_gen_pkg : FSM/mode encodings and default divisors for the
//                        cascaded tick generator.   Rev 1.0
// ============================================================================
`default_nettype none

package cascade_tick_gen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DIV_BAUD    = 10000;
  localparam int DIV_REFRESH = 1000;

  // A single-stage build still needs a 1-bit selector.
  function automatic int sel_width(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cascade_tick_gen_if.sv
// ============================================================================
// cascade_tick_gen_if : control and status bundle of the cascaded tick
//                       generator.   Rev 1.0
// ============================================================================
`default_nettype none

interface cascade_tick_gen_if
  import cascade_tick_gen_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int CNT_W  = 15
) ();

  localparam int SEL_W = sel_width(STAGES);

  logic                    en;
  logic                    clr;
  logic                    mode;
  logic                    start;
  logic                    div_load;
  logic [SEL_W-1:0]        div_sel;
  logic [CNT_W-1:0]        div_val;
  logic [STAGES-1:0]       stage_tick;
  logic                    tick;
  logic                    busy;
  logic [STAGES*CNT_W-1:0] cnt_flat;

  modport master (
    output en, clr, mode, start, div_load, div_sel, div_val,
    input  stage_tick, tick, busy, cnt_flat
  );

  modport slave (
    input  en, clr, mode, start, div_load, div_sel, div_val,
    output stage_tick, tick, busy, cnt_flat
  );

endinterface

`default_nettype wire

// File: rtl/cascade_tick_gen_tick_stage.sv
// ============================================================================
// tick_stage : one prescaler stage; counts carries up to its terminal value,
//              wraps, and emits a registered one-cycle tick.   Rev 1.0
// ============================================================================
`default_nettype none

module tick_stage #(
  parameter int CNT_W = 15
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             carry_in,
  input  wire logic [CNT_W-1:0] div,
  output logic      [CNT_W-1:0] cnt,
  output logic                  carry_out,
  output logic                  tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;
  logic             wrap;

  // >= rather than == so a divisor lowered below the count still wraps.
  assign wrap      = (cnt_q >= div);
  assign carry_out = carry_in & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (carry_in) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= carry_out & ~clr;
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/cascade_tick_gen.sv
// ============================================================================
// cascade_tick_gen : N-stage cascaded prescaler with run-time divisors,
//                    periodic/one-shot modes and one-cycle tick pulses. Rev 1.0
// ============================================================================
`default_nettype none

module cascade_tick_gen
  import cascade_tick_gen_pkg::*;
#(
  parameter int STAGES  = 2,
  parameter int CNT_W   = 15,
  parameter int DEF_DIV = 10000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cascade_tick_gen_if.slave bus
);

  logic [CNT_W-1:0]  div_q [STAGES];
  logic [CNT_W-1:0]  cnt_w [STAGES];
  logic [STAGES:0]   carry;
  logic [STAGES-1:0] stage_tick_w;
  logic              mode_q;
  logic              busy_q;
  logic              clr_eff;
  logic              adv;
  state_e            state_q, state_d;

  // A mode switch restarts everything, exactly like an explicit clear.
  assign clr_eff = bus.clr | (bus.mode != mode_q);

  assign adv      = (bus.mode == MODE_ONESHOT) ? (bus.en & (state_q == ST_RUN)) : bus.en;
  assign carry[0] = adv;

  // Divisor writes are not blocked by clear; the compare sees the old value this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        div_q[k] <= CNT_W'(DEF_DIV);
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.div_load && (32'(bus.div_sel) == k)) begin
          div_q[k] <= bus.div_val;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_eff) begin
      state_d = ST_IDLE;
    end else if (bus.mode == MODE_ONESHOT) begin
      case (state_q)
        ST_IDLE: if (bus.start)     state_d = ST_RUN;
        ST_RUN:  if (carry[STAGES]) state_d = ST_IDLE;
        default:                    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PERIODIC;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= bus.mode;
      busy_q  <= bus.en;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    tick_stage #(
      .CNT_W (CNT_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_eff),
      .carry_in  (carry[k]),
      .div       (div_q[k]),
      .cnt       (cnt_w[k]),
      .carry_out (carry[k+1]),
      .tick      (stage_tick_w[k])
    );
    assign bus.cnt_flat[k*CNT_W +: CNT_W] = cnt_w[k];
  end

  assign bus.stage_tick = stage_tick_w;
  assign bus.tick       = stage_tick_w[STAGES-1];
  assign bus.busy       = (bus.mode == MODE_ONESHOT) ? (state_q == ST_RUN) : busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cascade_tick_gen.sv
// ============================================================================
// tb_cascade_tick_gen : directed self-checking bench, STAGES=2, CNT_W=4,
//                       DEF_DIV=3 (nominal period 16).   Rev 1.0
// ============================================================================
`default_nettype none

module tb_cascade_tick_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cascade_tick_gen_if #(.STAGES(2), .CNT_W(4)) bus ();

  cascade_tick_gen #(
    .STAGES  (2),
    .CNT_W   (4),
    .DEF_DIV (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.mode = m; bus.start = 1'b0;
    bus.div_load = 1'b0; bus.div_sel = 1'b0; bus.div_val = 4'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    bus.en = 1'b1;
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.cnt_flat !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", bus.cnt_flat); end
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.stage_tick !== 2'b00) begin failures++; $display("FAIL reset_stage_tick got=%b exp=00", bus.stage_tick); end
    rst = 1'b0;
  endtask

  task automatic test_periodic();
    logic [1:0] exp_st;
    logic [7:0] exp_cnt;
    do_reset(1'b0);
    bus.en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      exp_st  = {(n % 16 == 0), (n % 4 == 0)};
      exp_cnt = {4'((n / 4) % 4), 4'(n % 4)};
      checks++; if (bus.tick !== exp_st[1]) begin failures++; $display("FAIL periodic_tick n=%0d got=%b exp=%b", n, bus.tick, exp_st[1]); end
      checks++; if (bus.stage_tick !== exp_st) begin failures++; $display("FAIL periodic_stage_tick n=%0d got=%b exp=%b", n, bus.stage_tick, exp_st); end
      checks++; if (bus.cnt_flat !== exp_cnt) begin failures++; $display("FAIL periodic_cnt n=%0d got=%h exp=%h", n, bus.cnt_flat, exp_cnt); end
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL periodic_busy got=%b exp=1", bus.busy); end
  endtask

  task automatic test_div_load();
    logic exp_tick;
    do_reset(1'b0);
    bus.en = 1'b1;
    repeat (3) step();
    checks++; if (bus.cnt_flat !== 8'h03) begin failures++; $display("FAIL divload_pre_cnt got=%h exp=03", bus.cnt_flat); end
    bus.div_load = 1'b1; bus.div_sel = 1'b0; bus.div_val = 4'd1;
    step();
    bus.div_load = 1'b0;
    checks++; if (bus.cnt_flat !== 8'h10) begin failures++; $display("FAIL divload_wrap_cnt got=%h exp=10", bus.cnt_flat); end
    checks++; if (bus.stage_tick !== 2'b01) begin failures++; $display("FAIL divload_wrap_tick got=%b exp=01", bus.stage_tick); end
    for (int n = 5; n <= 26; n++) begin
      step();
      exp_tick = (n == 10) || (n == 18) || (n == 26);
      checks++; if (bus.tick !== exp_tick) begin failures++; $display("FAIL divload_tick n=%0d got=%b exp=%b", n, bus.tick, exp_tick); end
      if (n == 6) begin
        checks++; if (bus.cnt_flat !== 8'h20) begin failures++; $display("FAIL divload_cnt n=6 got=%h exp=20", bus.cnt_flat); end
      end
    end
  endtask

  task automatic test_div_below_count();
    do_reset(1'b0);
    bus.en = 1'b1;
    repeat (2) step();
    bus.en = 1'b0;
    bus.div_load = 1'b1; bus.div_sel = 1'b0; bus.div_val = 4'd1;
    step();
    bus.div_load = 1'b0;
    checks++; if (bus.cnt_flat !== 8'h02) begin failures++; $display("FAIL below_hold_cnt got=%h exp=02", bus.cnt_flat); end
    bus.en = 1'b1;
    step();
    checks++; if (bus.cnt_flat !== 8'h10) begin failures++; $display("FAIL below_wrap_cnt got=%h exp=10", bus.cnt_flat); end
    checks++; if (bus.stage_tick !== 2'b01) begin failures++; $display("FAIL below_wrap_tick got=%b exp=01", bus.stage_tick); end
  endtask

  task automatic test_div_zero();
    logic [1:0] exp_st;
    do_reset(1'b0);
    bus.div_load = 1'b1; bus.div_sel = 1'b0; bus.div_val = 4'd0;
    step();
    bus.div_sel = 1'b1; bus.div_val = 4'd1;
    step();
    bus.div_load = 1'b0;
    bus.en = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      exp_st = {(n % 2 == 0), 1'b1};
      checks++; if (bus.stage_tick !== exp_st) begin failures++; $display("FAIL divzero_stage_tick n=%0d got=%b exp=%b", n, bus.stage_tick, exp_st); end
    end
  endtask

  task automatic test_oneshot();
    logic exp_busy, exp_tick;
    do_reset(1'b1);
    step();
    bus.en = 1'b1;
    repeat (2) step();
    checks++; if (bus.cnt_flat !== 8'h00) begin failures++; $display("FAIL oneshot_idle_cnt got=%h exp=00", bus.cnt_flat); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL oneshot_idle_busy got=%b exp=0", bus.busy); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL oneshot_start_busy got=%b exp=1", bus.busy); end
    for (int n = 1; n <= 20; n++) begin
      bus.start = (n == 5);
      step();
      exp_busy = (n < 16);
      exp_tick = (n == 16);
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL oneshot_busy n=%0d got=%b exp=%b", n, bus.busy, exp_busy); end
      checks++; if (bus.tick !== exp_tick) begin failures++; $display("FAIL oneshot_tick n=%0d got=%b exp=%b", n, bus.tick, exp_tick); end
      if (n == 8) begin
        checks++; if (bus.cnt_flat !== 8'h20) begin failures++; $display("FAIL oneshot_cnt n=8 got=%h exp=20", bus.cnt_flat); end
      end
    end
    bus.start = 1'b0;
    checks++; if (bus.cnt_flat !== 8'h00) begin failures++; $display("FAIL oneshot_end_cnt got=%h exp=00", bus.cnt_flat); end
  endtask

  task automatic test_en_hold();
    logic exp_tick;
    do_reset(1'b0);
    bus.en = 1'b1;
    repeat (9) step();
    checks++; if (bus.cnt_flat !== 8'h21) begin failures++; $display("FAIL hold_pre_cnt got=%h exp=21", bus.cnt_flat); end
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.cnt_flat !== 8'h21) begin failures++; $display("FAIL hold_cnt i=%0d got=%h exp=21", i, bus.cnt_flat); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_busy i=%0d got=%b exp=0", i, bus.busy); end
    end
    bus.en = 1'b1;
    for (int n = 15; n <= 25; n++) begin
      step();
      exp_tick = (n == 21);
      checks++; if (bus.tick !== exp_tick) begin failures++; $display("FAIL hold_tick n=%0d got=%b exp=%b", n, bus.tick, exp_tick); end
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hold_resume_busy got=%b exp=1", bus.busy); end
  endtask

  task automatic test_clr();
    logic exp_tick;
    do_reset(1'b0);
    bus.en = 1'b1;
    repeat (15) step();
    checks++; if (bus.cnt_flat !== 8'h33) begin failures++; $display("FAIL clr_pre_cnt got=%h exp=33", bus.cnt_flat); end
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    checks++; if (bus.cnt_flat !== 8'h00) begin failures++; $display("FAIL clr_cnt got=%h exp=00", bus.cnt_flat); end
    checks++; if (bus.stage_tick !== 2'b00) begin failures++; $display("FAIL clr_stage_tick got=%b exp=00", bus.stage_tick); end
    for (int n = 1; n <= 20; n++) begin
      step();
      exp_tick = (n == 16);
      checks++; if (bus.tick !== exp_tick) begin failures++; $display("FAIL clr_tick n=%0d got=%b exp=%b", n, bus.tick, exp_tick); end
    end
  endtask

  task automatic test_mode_change();
    do_reset(1'b0);
    bus.en = 1'b1;
    repeat (5) step();
    checks++; if (bus.cnt_flat !== 8'h11) begin failures++; $display("FAIL modechg_pre_cnt got=%h exp=11", bus.cnt_flat); end
    bus.mode = 1'b1;
    step();
    checks++; if (bus.cnt_flat !== 8'h00) begin failures++; $display("FAIL modechg_cnt got=%h exp=00", bus.cnt_flat); end
    step();
    checks++; if (bus.cnt_flat !== 8'h00) begin failures++; $display("FAIL modechg_idle_cnt got=%h exp=00", bus.cnt_flat); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL modechg_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_rst_mid();
    logic exp_busy, exp_tick;
    do_reset(1'b1);
    step();
    bus.div_load = 1'b1; bus.div_sel = 1'b0; bus.div_val = 4'd1;
    step();
    bus.div_load = 1'b0;
    bus.en = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    checks++; if (bus.cnt_flat !== 8'h11) begin failures++; $display("FAIL rstmid_pre_cnt got=%h exp=11", bus.cnt_flat); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.cnt_flat !== 8'h00) begin failures++; $display("FAIL rstmid_cnt got=%h exp=00", bus.cnt_flat); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL rstmid_tick got=%b exp=0", bus.tick); end
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      step();
      exp_busy = (n < 16);
      exp_tick = (n == 16);
      checks++; if (bus.tick !== exp_tick) begin failures++; $display("FAIL rstmid_div_tick n=%0d got=%b exp=%b", n, bus.tick, exp_tick); end
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL rstmid_div_busy n=%0d got=%b exp=%b", n, bus.busy, exp_busy); end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.mode = 1'b0; bus.start = 1'b0;
    bus.div_load = 1'b0; bus.div_sel = 1'b0; bus.div_val = 4'd0;
    test_reset();
    test_periodic();
    test_div_load();
    test_div_below_count();
    test_div_zero();
    test_oneshot();
    test_en_hold();
    test_clr();
    test_mode_change();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cascade_tick_gen.md
Name: cascade_tick_gen

Overview:
- Parametrised cascaded prescaler that produces a single-cycle timing tick every P = ∏(div[k]+1) enabled clocks.
- Successor to the fixed two-stage 10000×10000 baud/tick divider. Adds N stages, run-time divisors, enable/clear, one-shot mode, and true one-cycle tick pulses; the old divider's output stayed high for a whole lower-stage period.
- Feeds UART bit timing, display refresh and debounce sampling in the same design.

Parameters:
- STAGES, 2, number of cascaded counter stages (≥1).
- CNT_W, 15, width of each stage counter and divisor.
- DEF_DIV, 10000, reset value of every stage divisor; stage period is DEF_DIV+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; low freezes all counters.
- clr  in  1  synchronous restart: counters to 0, FSM to IDLE, no tick.
- mode  in  1  0 = periodic, 1 = one-shot.
- start  in  1  one-shot trigger pulse.
- div_load  in  1  write div_val into div[div_sel].
- div_sel  in  max(1,$clog2(STAGES))  stage index for div_load.
- div_val  in  CNT_W  new divisor (terminal count).
- stage_tick  out  STAGES  one-cycle wrap pulse per stage.
- tick  out  1  = stage_tick[STAGES-1].
- busy  out  1  counting active.
- cnt_flat  out  STAGES*CNT_W  concatenated live counters, stage 0 in the LSBs.

Behaviour:
- Reset (rst=1 at a clk edge): all counters 0; div[k]=DEF_DIV; FSM IDLE; stage_tick, tick, busy all 0.
- Priority: rst > clr > everything else. clr also clears the stage_tick register. div_load still executes in a clr cycle; it is not executed in a rst cycle.
- Advance condition `adv`:
  - mode 0: `adv` = en.
  - mode 1: `adv` = en & (state==RUN).
- Carry chain: c0 = adv; c(k+1) = c(k) & (cnt[k] ≥ div[k]).
- Stage update on each edge with c(k)=1:
  - cnt[k] ≥ div[k]: cnt[k] ← 0, and stage_tick[k] is high for the next cycle only.
  - otherwise: cnt[k] ← cnt[k]+1.
- With c(k)=0 the stage holds, and stage_tick[k] is 0 for the next cycle.
- The ≥ comparison means that loading a divisor below the current count wraps the stage on its next advance; the count never runs past the terminal.
- div_val=0 gives period 1: the stage passes every carry through and its tick is high whenever the stage is carried into.
- Counter arithmetic is unsigned CNT_W with no overflow; the count is bounded by div.
- div_load timing: the write lands at the edge. The comparison in that same cycle uses the old divisor, and the new divisor takes effect from the next cycle.
- div_sel ≥ STAGES: the write is ignored.
- Latency: stage_tick is registered. With all div = D and en held high from the first edge, tick goes high right after edge (D+1)^STAGES and then once every (D+1)^STAGES edges.
- FSM (states IDLE, RUN) is meaningful in mode 1 only:
  - IDLE, start=1 → RUN. Counters are already 0.
  - RUN, top stage wraps → IDLE; tick pulses on that wrap; all counters are 0 after the wrap.
  - start during RUN: ignored, no restart.
  - start and clr in the same cycle: clr wins, FSM goes to IDLE.
- busy:
  - mode 0: busy = en, registered (valid one cycle after en).
  - mode 1: busy = (state==RUN).
- mode change mid-operation (registered mode ≠ mode): acts as clr for that cycle.
- en low mid-period: counters hold; counting resumes exactly where it stopped. No tick is lost or duplicated.

Decomposition:
- Shared package/header holds:
  - FSM encodings ST_IDLE = 1'b0, ST_RUN = 1'b1.
  - MODE_PERIODIC, MODE_ONESHOT.
  - Default divisor constants: DIV_BAUD, DIV_REFRESH.
- One natural sub-module, `tick_stage`, instantiated STAGES times by generate:
  - Inputs: clk, rst, clr, carry_in, div.
  - Outputs: cnt, carry_out, tick.
- The top level holds the divisor register file, FSM, mode-change detect and busy logic.

Test Plan:
- STAGES=2, CNT_W=4, DEF_DIV=3, mode 0, en=1 for 40 cycles after reset → tick high at cycles 16 and 32 only, each 1 cycle wide; stage_tick[0] every 4 cycles.
- Same config, load div[0]=1 while cnt[0]=3 → stage 0 wraps on its next advance; thereafter tick period = 2·4 = 8 cycles.
- Mode 1, start pulse, en=1 → busy high for 16 cycles, one tick, busy low; a second start mid-run has no effect on timing.
- Mode 0, drop en for 5 cycles at cnt_flat=8'h21 → cnt_flat holds 8'h21; the next tick arrives 5 cycles later than nominal.
- clr at cnt_flat=8'h33 (tick about to fire) → no tick, counters 0, next tick 16 cycles after clr deasserts.
- rst asserted mid-run in mode 1 → next cycle: counters 0, busy 0, tick 0, div[k] back to 3.
